pc_update_unit: RTL and testbench

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

---
 rtl/pc_update_if.sv | 37 +++
 rtl/pc_update_unit.sv | 117 +++++++++++
 tb/tb_pc_update_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pc_update_if.sv
// pc_update_if -- bundle between the control FSM / datapath and the PC update
// unit.
//
// Control side (master) drives:
//   PCWrite, PCWriteCond, PCSource, Branch, TargetLoad, imm, jump_field,
//   alu_result.
// PC unit side (slave) drives:
//   PC, PC_plus4, Target, Taken, Fault.
interface pc_update_if #(
  parameter int word_size = 32
);
  logic                 PCWrite;
  logic                 PCWriteCond;
  logic [1:0]           PCSource;
  logic                 Branch;
  logic                 TargetLoad;
  logic [word_size-1:0] imm;
  logic [25:0]          jump_field;
  logic [word_size-1:0] alu_result;
  logic [word_size-1:0] PC;
  logic [word_size-1:0] PC_plus4;
  logic [word_size-1:0] Target;
  logic                 Taken;
  logic                 Fault;

  modport master (
    output PCWrite, PCWriteCond, PCSource, Branch, TargetLoad, imm,
           jump_field, alu_result,
    input  PC, PC_plus4, Target, Taken, Fault
  );

  modport slave (
    input  PCWrite, PCWriteCond, PCSource, Branch, TargetLoad, imm,
           jump_field, alu_result,
    output PC, PC_plus4, Target, Taken, Fault
  );
endinterface

// File: rtl/pc_update_unit.sv
// pc_update_unit -- program counter and branch-target register for a
// multi-cycle CPU.
//
// Ports:
//   clk  : single clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : pc_update_if.slave
//          inputs  : PCWrite, PCWriteCond, PCSource, Branch, TargetLoad,
//                    imm (word offset), jump_field, alu_result
//          outputs : PC, Target, Taken, Fault (registered),
//                    PC_plus4 (combinational from PC only)
//
// A selected candidate that is not word aligned is never loaded; it raises a
// sticky Fault that freezes the PC until reset.
module pc_update_unit #(
  parameter int                   word_size    = 32,
  parameter logic [word_size-1:0] reset_vector = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_update_if.slave    bus
);

  logic [word_size-1:0] pc_q, pc_d;
  logic [word_size-1:0] target_q, target_d;
  logic                 taken_q, taken_d;
  logic                 fault_q, fault_d;

  logic [word_size-1:0] pc_plus4_s;
  logic [word_size-1:0] jump_addr_s;
  logic [word_size-1:0] src_mux_s;
  logic [word_size-1:0] cand_s;
  logic                 update_sel_s;
  logic                 cond_path_s;

  // Sequential increment and jump address depend only on the current PC.
  always_comb begin
    pc_plus4_s  = pc_q + word_size'(4);
    jump_addr_s = {pc_plus4_s[word_size-1:28], bus.jump_field, 2'b00};
  end

  // Next-state: candidate selection, alignment check, sticky fault, target.
  always_comb begin
    pc_d         = pc_q;
    target_d     = target_q;
    taken_d      = 1'b0;
    fault_d      = fault_q;
    src_mux_s    = pc_plus4_s;
    cand_s       = pc_plus4_s;
    update_sel_s = 1'b0;
    cond_path_s  = 1'b0;

    case (bus.PCSource)
      2'b00:   src_mux_s = pc_plus4_s;
      2'b01:   src_mux_s = bus.alu_result;
      2'b10:   src_mux_s = jump_addr_s;
      2'b11:   src_mux_s = target_q;
      default: src_mux_s = pc_plus4_s;
    endcase

    // PCWrite wins; Branch only matters on the conditional path.
    if (bus.PCWrite) begin
      update_sel_s = 1'b1;
      cand_s       = src_mux_s;
    end else if (bus.PCWriteCond && bus.Branch) begin
      update_sel_s = 1'b1;
      cond_path_s  = 1'b1;
      cand_s       = target_q;
    end else begin
      update_sel_s = 1'b0;
      cand_s       = pc_plus4_s;
    end

    // Once faulted, the PC is frozen regardless of strobes.
    if (fault_q) begin
      pc_d = pc_q;
    end else if (update_sel_s) begin
      if (cand_s[1:0] == 2'b00) begin
        pc_d    = cand_s;
        taken_d = cond_path_s;
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      pc_d = pc_q;
    end

    // Target is always computed from the pre-edge PC.
    if (bus.TargetLoad) begin
      target_d = pc_plus4_s + (bus.imm << 2);
    end else begin
      target_d = target_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= reset_vector;
      target_q <= '0;
      taken_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PC_plus4 = pc_plus4_s;
  assign bus.Target   = target_q;
  assign bus.Taken    = taken_q;
  assign bus.Fault    = fault_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit -- directed scenarios followed by random stimulus, every
// cycle compared against a behavioural model of the PC unit.
module tb_pc_update_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_update_if #(.word_size(32)) bus ();

  pc_update_unit #(.word_size(32), .reset_vector(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_target;
  logic        m_taken;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cycle(input logic r, input logic pw, input logic pwc,
                       input logic [1:0] src, input logic br, input logic tl,
                       input logic [31:0] imm_v, input logic [25:0] jf,
                       input logic [31:0] alu);
    logic [31:0] p4, cand, new_tgt;
    logic        upd, tk;
    rst            = r;
    bus.PCWrite    = pw;
    bus.PCWriteCond = pwc;
    bus.PCSource   = src;
    bus.Branch     = br;
    bus.TargetLoad = tl;
    bus.imm        = imm_v;
    bus.jump_field = jf;
    bus.alu_result = alu;
    @(posedge clk);
    if (r) begin
      m_pc = RV; m_target = 32'd0; m_taken = 1'b0; m_fault = 1'b0;
    end else begin
      p4      = m_pc + 32'd4;
      new_tgt = tl ? p4 + imm_v * 32'd4 : m_target;
      upd     = 1'b0;
      cand    = 32'd0;
      if (pw) begin
        upd = 1'b1;
        if (src == 2'd0)      cand = p4;
        else if (src == 2'd1) cand = alu;
        else if (src == 2'd2) cand = (p4 & 32'hF000_0000) + {6'd0, jf} * 32'd4;
        else                  cand = m_target;
      end else if (pwc && br) begin
        upd  = 1'b1;
        cand = m_target;
      end
      tk = 1'b0;
      if (!m_fault && upd) begin
        if (cand % 32'd4 == 32'd0) begin
          m_pc = cand;
          tk   = !pw;
        end else begin
          m_fault = 1'b1;
        end
      end
      m_taken  = tk;
      m_target = new_tgt;
    end
    #1;
    chk("pc",       bus.PC,       m_pc);
    chk("pc_plus4", bus.PC_plus4, m_pc + 32'd4);
    chk("target",   bus.Target,   m_target);
    chk("taken",    {31'd0, bus.Taken}, {31'd0, m_taken});
    chk("fault",    {31'd0, bus.Fault}, {31'd0, m_fault});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic set_pc(input logic [31:0] v);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 26'd0, v);
  endtask

  initial begin
    logic r, pw, pwc, br, tl;
    logic [1:0]  src;
    logic [31:0] alu, imm_v;
    rst = 1'b1;
    bus.PCWrite = 1'b0; bus.PCWriteCond = 1'b0; bus.PCSource = 2'd0;
    bus.Branch = 1'b0; bus.TargetLoad = 1'b0; bus.imm = 32'd0;
    bus.jump_field = 26'd0; bus.alu_result = 32'd0;
    m_pc = 32'd0; m_target = 32'd0; m_taken = 1'b0; m_fault = 1'b0;
    @(negedge clk);

    // Reset state and sequential fetch
    cycle(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 32'h5, 26'h3, 32'h88);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_pc_plus4", bus.PC_plus4, 32'h4);
    chk("rst_target", bus.Target, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
      chk("fetch_pc", bus.PC, 32'(4 * i));
    end

    // Taken branch
    set_pc(32'h40);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0);
    chk("br_target", bus.Target, 32'h3C);
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("br_pc", bus.PC, 32'h3C);
    chk("br_taken", {31'd0, bus.Taken}, 32'd1);
    idle();
    chk("br_taken_pulse", {31'd0, bus.Taken}, 32'd0);

    // Not-taken branch
    set_pc(32'h40);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("nt_pc", bus.PC, 32'h40);
    chk("nt_taken", {31'd0, bus.Taken}, 32'd0);

    // Priority and jump
    set_pc(32'h1000_0000);
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 32'd0, 26'h000_0010, 32'd0);
    chk("jmp_pc", bus.PC, 32'h1000_0040);
    chk("jmp_taken", {31'd0, bus.Taken}, 32'd0);

    // TargetLoad together with a PC write
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'd1, 26'd0, 32'd0);
    chk("same_edge_target", bus.Target, 32'h1000_0048);
    chk("same_edge_pc", bus.PC, 32'h1000_0044);

    // Misalignment, sticky fault, reset recovery
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 26'd0, 32'h0000_0102);
    chk("mis_pc", bus.PC, 32'h1000_0044);
    chk("mis_fault", {31'd0, bus.Fault}, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("mis_hold_pc", bus.PC, 32'h1000_0044);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("mis_rst_pc", bus.PC, RV);
    chk("mis_rst_fault", {31'd0, bus.Fault}, 32'd0);

    // Reset discards a latched target
    set_pc(32'h200);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h10, 26'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("rst_discard_pc", bus.PC, 32'h0);

    // Wrap
    set_pc(32'hFFFF_FFFC);
    chk("wrap_plus4", bus.PC_plus4, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    chk("wrap_pc", bus.PC, 32'h0);
    chk("wrap_fault", {31'd0, bus.Fault}, 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      r     = ($urandom_range(0, 24) == 0);
      pw    = ($urandom_range(0, 2) == 0);
      pwc   = ($urandom_range(0, 2) == 0);
      br    = $urandom_range(0, 1);
      tl    = ($urandom_range(0, 2) == 0);
      src   = 2'($urandom_range(0, 3));
      alu   = $urandom;
      if ($urandom_range(0, 15) != 0) alu = alu & 32'hFFFF_FFFC;
      imm_v = 32'($signed(16'($urandom)));
      cycle(r, pw, pwc, src, br, tl, imm_v, 26'($urandom), alu);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
